// File: rtl/ps2_scancode_receiver.sv
`default_nettype none
// ============================================================================
// Module   : ps2_scancode_receiver
// Purpose  : Receives PS/2 keyboard frames, decodes set-2 scan codes, folds the
//            E0 (extended) and F0 (break) prefixes into per-code flags, and
//            buffers the decoded codes in a first-word fall-through FIFO with a
//            valid/ack handshake. Sticky error flags report parity errors,
//            framing errors and FIFO overflow.
// Ports    : clk            system clock
//            rst_n          asynchronous active-low reset
//            i_ps2_clk      raw PS/2 clock pin (asynchronous, idle high)
//            i_ps2_data     raw PS/2 data pin (asynchronous, idle high)
//            o_data         scan code at FIFO head
//            o_extended     head entry was preceded by E0
//            o_break        head entry was preceded by F0
//            o_valid        FIFO non-empty
//            i_ack          pop head on the next rising edge when o_valid=1
//            o_parity_error sticky parity failure
//            o_frame_error  sticky bad stop bit / mid-frame timeout
//            o_overflow     sticky code dropped because FIFO was full
//            i_clear_err    synchronous clear of the sticky flags
// Revision : 1.0 - initial release
// ============================================================================
module ps2_scancode_receiver #(
  parameter int FIFO_DEPTH     = 4,
  parameter int FIFO_AW        = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_data,
  output logic [7:0] o_data,
  output logic       o_extended,
  output logic       o_break,
  output logic       o_valid,
  input  logic       i_ack,
  output logic       o_parity_error,
  output logic       o_frame_error,
  output logic       o_overflow,
  input  logic       i_clear_err
);

  localparam int         FCW       = $clog2(FILTER_LEN + 1);
  localparam int         TCW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam int         CW        = FIFO_AW + 1;
  localparam logic [7:0] C_PFX_EXT = 8'hE0;
  localparam logic [7:0] C_PFX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchronisers (reset to the idle-high bus level)
  // --------------------------------------------------------------------------
  logic r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= i_ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= i_ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // --------------------------------------------------------------------------
  // PS/2 clock glitch filter: the filtered level follows the synchronised
  // level only after FILTER_LEN consecutive differing samples.
  // --------------------------------------------------------------------------
  logic           r_filt;
  logic [FCW-1:0] r_fcnt;
  logic           w_filt_change;
  logic           w_bit_event;

  assign w_filt_change = (r_clk_s2 != r_filt) && (r_fcnt == FCW'(FILTER_LEN - 1));
  // Falling edge of the filtered clock, seen in the same cycle as the change.
  assign w_bit_event   = w_filt_change && r_filt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt <= 1'b1;
      r_fcnt <= '0;
    end else if (r_clk_s2 == r_filt) begin
      r_fcnt <= '0;
    end else if (w_filt_change) begin
      r_filt <= r_clk_s2;
      r_fcnt <= '0;
    end else begin
      r_fcnt <= r_fcnt + FCW'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  state_t         r_state, w_state_next;
  logic [7:0]     r_shift;
  logic [2:0]     r_bitcnt;
  logic           r_parity;
  logic [TCW-1:0] r_tcnt;
  logic           w_timeout;
  logic           w_shift_en, w_par_en, w_accept, w_perr, w_ferr, w_fail;
  logic           w_par_ok;

  assign w_par_ok  = ^{r_shift, r_parity};
  assign w_timeout = (r_state != S_IDLE) && !w_bit_event &&
                     (r_tcnt == TCW'(TIMEOUT_CYCLES - 1));
  assign w_fail    = w_perr | w_ferr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_shift_en   = 1'b0;
    w_par_en     = 1'b0;
    w_accept     = 1'b0;
    w_perr       = 1'b0;
    w_ferr       = 1'b0;
    if (w_timeout) begin
      w_state_next = S_IDLE;
      w_ferr       = 1'b1;
    end else if (w_bit_event) begin
      case (r_state)
        S_IDLE: begin
          // A high data level here is a spurious edge, not a start bit.
          if (!r_dat_s2) w_state_next = S_DATA;
        end
        S_DATA: begin
          w_shift_en = 1'b1;
          if (r_bitcnt == 3'd7) w_state_next = S_PARITY;
        end
        S_PARITY: begin
          w_par_en     = 1'b1;
          w_state_next = S_STOP;
        end
        S_STOP: begin
          w_state_next = S_IDLE;
          w_perr       = ~w_par_ok;
          w_ferr       = ~r_dat_s2;
          w_accept     = w_par_ok & r_dat_s2;
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= '0;
    end else if ((r_state == S_IDLE) || w_bit_event) begin
      r_tcnt <= '0;
    end else begin
      r_tcnt <= r_tcnt + TCW'(1);
    end
  end

  // Datapath: bits arrive LSB first, so shift right from the MSB side.
  logic       r_dec_valid;
  logic [7:0] r_dec_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= '0;
      r_bitcnt    <= '0;
      r_parity    <= 1'b0;
      r_dec_valid <= 1'b0;
      r_dec_byte  <= '0;
    end else begin
      r_dec_valid <= w_accept;
      if (w_accept) r_dec_byte <= r_shift;
      if (w_shift_en) begin
        r_shift  <= {r_dat_s2, r_shift[7:1]};
        r_bitcnt <= r_bitcnt + 3'd1;
      end else if (r_state == S_IDLE) begin
        r_bitcnt <= '0;
      end
      if (w_par_en) r_parity <= r_dat_s2;
    end
  end

  // --------------------------------------------------------------------------
  // Decode step: prefixes only update flags; other bytes are pushed
  // --------------------------------------------------------------------------
  logic r_ext, r_brk;
  logic w_is_ext, w_is_brk, w_push;

  assign w_is_ext = r_dec_valid && (r_dec_byte == C_PFX_EXT);
  assign w_is_brk = r_dec_valid && (r_dec_byte == C_PFX_BRK);
  assign w_push   = r_dec_valid && !w_is_ext && !w_is_brk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (w_fail) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (w_is_ext) begin
      r_ext <= 1'b1;
    end else if (w_is_brk) begin
      r_brk <= 1'b1;
    end else if (w_push) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // First-word fall-through FIFO of {ext, brk, code}
  // --------------------------------------------------------------------------
  logic [9:0]         r_mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic               w_full, w_empty, w_pop, w_wr, w_drop;

  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = i_ack & ~w_empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign w_wr    = w_push & (~w_full | w_pop);
  assign w_drop  = w_push & w_full & ~w_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= {r_ext, r_brk, r_dec_byte};
        r_wr_ptr        <= r_wr_ptr + FIFO_AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sticky error flags: a new error takes priority over a clear request
  // --------------------------------------------------------------------------
  logic r_perr_flag, r_ferr_flag, r_ovf_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perr_flag <= 1'b0;
      r_ferr_flag <= 1'b0;
      r_ovf_flag  <= 1'b0;
    end else begin
      if (w_perr)           r_perr_flag <= 1'b1;
      else if (i_clear_err) r_perr_flag <= 1'b0;
      if (w_ferr)           r_ferr_flag <= 1'b1;
      else if (i_clear_err) r_ferr_flag <= 1'b0;
      if (w_drop)           r_ovf_flag  <= 1'b1;
      else if (i_clear_err) r_ovf_flag  <= 1'b0;
    end
  end

  assign {o_extended, o_break, o_data} = r_mem[r_rd_ptr];
  assign o_valid        = ~w_empty;
  assign o_parity_error = r_perr_flag;
  assign o_frame_error  = r_ferr_flag;
  assign o_overflow     = r_ovf_flag;

endmodule
`default_nettype wire
